// File: rtl/uart_msg_streamer.sv
// Byte-buffered message streamer feeding a UART transmitter: sends msg_len bytes
// from an internal buffer, one-shot or repeating with an idle gap between messages.
module uart_msg_streamer #(
   parameter  int DEPTH       = 16,
   parameter  int GAP_CYCLES  = 2097152,
   parameter  int ACK_TIMEOUT = 16,
   localparam int AW          = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          continuous,
   input  logic [AW:0]   msg_len,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic          tx_busy,
   output logic          transmit,
   output logic [7:0]    tx_byte,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] char_idx,
   output logic          retry_err
);

   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   localparam logic [AW:0]   DEPTH_LEN = (AW + 1)'(DEPTH);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_GAP
   } state_t;

   state_t        state, state_d;
   logic [AW:0]   len_q, len_d;
   logic [AW-1:0] idx_d;
   logic [7:0]    byte_d;
   logic [TW-1:0] to_cnt, to_d;
   logic [GW-1:0] gap_cnt, gap_d;
   logic          retry_d;
   logic          last_byte;

   logic [7:0] mem [DEPTH];

   // NOTE: the buffer is plain storage with no reset, so it maps onto RAM and
   // keeps its contents across a reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign busy      = (state != S_IDLE);
   assign last_byte = ({1'b0, char_idx} == (len_q - 1'b1));

   // NOTE: every signal gets its default first so no path leaves one unassigned
   // and no latch is inferred.
   always_comb begin
      state_d  = state;
      len_d    = len_q;
      idx_d    = char_idx;
      byte_d   = tx_byte;
      to_d     = to_cnt;
      gap_d    = gap_cnt;
      retry_d  = retry_err;
      transmit = 1'b0;
      done     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if ((start || continuous) && (msg_len != '0)) begin
               len_d   = (msg_len > DEPTH_LEN) ? DEPTH_LEN : msg_len;
               idx_d   = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            byte_d  = mem[char_idx];
            state_d = S_SEND;
         end
         S_SEND: begin
            if (!tx_busy) begin
               transmit = 1'b1;
               to_d     = '0;
               state_d  = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (tx_busy) begin
               state_d = S_WAIT_DONE;
            end else if (to_cnt == TO_LAST) begin
               // The UART never picked the byte up: resend the same byte.
               retry_d = 1'b1;
               state_d = S_SEND;
            end else begin
               to_d = to_cnt + 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) begin
               if (last_byte) begin
                  done    = 1'b1;
                  idx_d   = '0;
                  gap_d   = '0;
                  state_d = continuous ? S_GAP : S_IDLE;
               end else begin
                  idx_d   = char_idx + 1'b1;
                  state_d = S_LOAD;
               end
            end
         end
         S_GAP: begin
            if (gap_cnt == GAP_LAST) begin
               gap_d   = '0;
               state_d = S_IDLE;
            end else begin
               gap_d = gap_cnt + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values computed above.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         len_q     <= '0;
         char_idx  <= '0;
         tx_byte   <= '0;
         to_cnt    <= '0;
         gap_cnt   <= '0;
         retry_err <= 1'b0;
      end else begin
         state     <= state_d;
         len_q     <= len_d;
         char_idx  <= idx_d;
         tx_byte   <= byte_d;
         to_cnt    <= to_d;
         gap_cnt   <= gap_d;
         retry_err <= retry_d;
      end
   end

endmodule

// File: tb/tb_uart_msg_streamer.sv
// Scoreboard bench for uart_msg_streamer: stimulus pushes expected bytes, a monitor
// pops and compares them on every transmit strobe; a small UART model drives tx_busy.
module tb_uart_msg_streamer;

   localparam int DEPTH = 16;
   localparam int GAP   = 8;
   localparam int ACKTO = 4;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          continuous = 1'b0;
   logic [AW:0]   msg_len = '0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [7:0]    wr_data = '0;
   logic          tx_busy = 1'b0;
   logic          transmit;
   logic [7:0]    tx_byte;
   logic          busy;
   logic          done;
   logic [AW-1:0] char_idx;
   logic          retry_err;

   uart_msg_streamer #(
      .DEPTH      (DEPTH),
      .GAP_CYCLES (GAP),
      .ACK_TIMEOUT(ACKTO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .continuous(continuous),
      .msg_len   (msg_len),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .tx_busy   (tx_busy),
      .transmit  (transmit),
      .tx_byte   (tx_byte),
      .busy      (busy),
      .done      (done),
      .char_idx  (char_idx),
      .retry_err (retry_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests  = 0;
   int failed = 0;
   int n_tx   = 0;
   int n_done = 0;
   logic [7:0] exp_q [$];
   int tx_cycs [$];
   int done_cycs [$];
   bit uart_ack = 1'b1;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wr(input int addr, input logic [7:0] data);
      wr_en   = 1'b1;
      wr_addr = AW'(addr);
      wr_data = data;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int k = 0;
      while (n_done < target && k < budget) begin
         tick();
         k++;
      end
      check("done_reached", int'(n_done >= target), 1);
   endtask

   task automatic wait_tx(input int target, input int budget);
      int k = 0;
      while (n_tx < target && k < budget) begin
         tick();
         k++;
      end
      check("tx_reached", int'(n_tx >= target), 1);
   endtask

   task automatic wait_idx(input int v, input int budget);
      int k = 0;
      while (int'(char_idx) != v && k < budget) begin
         tick();
         k++;
      end
      check("idx_reached", int'(char_idx), v);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_transmit"}, int'(transmit), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_tx_byte"}, int'(tx_byte), 0);
      check({tag, "_char_idx"}, int'(char_idx), 0);
      check({tag, "_retry_err"}, int'(retry_err), 0);
   endtask

   // UART model: busy for 3 cycles after an accepted transmit strobe.
   initial begin : uart_model
      int  ucnt;
      bit  fire;
      ucnt = 0;
      forever begin
         @(negedge clk);
         fire = transmit;
         @(posedge clk);
         #1;
         if (fire && uart_ack) ucnt = 3;
         else if (ucnt > 0) ucnt--;
         tx_busy = (ucnt > 0);
      end
   end

   // Monitor: compares every transmitted byte against the scoreboard queue.
   initial begin : monitor
      logic [7:0] exp_b;
      forever begin
         @(negedge clk);
         if (transmit) begin
            n_tx++;
            tx_cycs.push_back(cyc);
            if (exp_q.size() == 0) begin
               tests++;
               failed++;
               $display("FAIL tx_unexpected: got byte 0x%0h, expected no transmit", tx_byte);
            end else begin
               exp_b = exp_q.pop_front();
               check("tx_byte", int'(tx_byte), int'(exp_b));
            end
         end
         if (done) begin
            n_done++;
            done_cycs.push_back(cyc);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      string s;
      int    base;
      int    dbase;
      int    st_cyc;
      bit    any_busy;
      s = "Hello World!\n\r";

      // Reset state
      repeat (3) tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      // Single message with the UART acknowledging
      for (int i = 0; i < 14; i++) wr(i, s[i]);
      for (int i = 0; i < 14; i++) exp_q.push_back(s[i]);
      msg_len = 5'd14;
      base    = n_tx;
      dbase   = n_done;
      st_cyc  = cyc;
      pulse_start();
      wait_done(dbase + 1, 300);
      check("hello_tx_count", n_tx - base, 14);
      check("hello_first_latency", tx_cycs[base] - st_cyc, 2);
      check("hello_byte_spacing", tx_cycs[base + 1] - tx_cycs[base], 6);
      tick();
      check("hello_idle_after", int'(busy), 0);
      check("hello_queue_empty", exp_q.size(), 0);
      check("hello_done_count", n_done - dbase, 1);

      // Continuous mode: gap between repeats
      msg_len = 5'd2;
      repeat (2) begin
         exp_q.push_back(s[0]);
         exp_q.push_back(s[1]);
      end
      base       = n_tx;
      dbase      = n_done;
      continuous = 1'b1;
      wait_done(dbase + 1, 200);
      wait_done(dbase + 2, 200);
      continuous = 1'b0;
      check("cont_gap_to_tx", tx_cycs[base + 2] - done_cycs[dbase], GAP + 3);
      check("cont_tx_count", n_tx - base, 4);
      tick();
      check("cont_idle_after", int'(busy), 0);

      // Continuous dropped during byte 3: finish, no gap
      for (int i = 0; i < 14; i++) exp_q.push_back(s[i]);
      msg_len    = 5'd14;
      base       = n_tx;
      dbase      = n_done;
      continuous = 1'b1;
      wait_idx(3, 100);
      continuous = 1'b0;
      wait_done(dbase + 1, 300);
      check("drop_tx_count", n_tx - base, 14);
      tick();
      check("drop_no_gap", int'(busy), 0);
      repeat (3) tick();
      check("drop_done_count", n_done - dbase, 1);

      // Reset on byte 5, then a full resend from byte 0
      for (int i = 0; i < 14; i++) exp_q.push_back(s[i]);
      base  = n_tx;
      dbase = n_done;
      pulse_start();
      wait_idx(5, 200);
      rst_n = 1'b0;
      tick();
      exp_q.delete();
      check_reset_outputs("midreset");
      rst_n = 1'b1;
      check("midreset_no_done", n_done - dbase, 0);
      check("midreset_tx_before", n_tx - base, 5);
      tick();
      for (int i = 0; i < 14; i++) exp_q.push_back(s[i]);
      base = n_tx;
      pulse_start();
      wait_done(dbase + 1, 300);
      check("resend_tx_count", n_tx - base, 14);
      check("resend_queue_empty", exp_q.size(), 0);

      // msg_len == 0 is ignored
      tick();
      msg_len  = '0;
      base     = n_tx;
      any_busy = 1'b0;
      pulse_start();
      repeat (10) begin
         if (busy) any_busy = 1'b1;
         tick();
      end
      check("len0_never_busy", int'(any_busy), 0);
      check("len0_no_tx", n_tx - base, 0);

      // msg_len == DEPTH+1 sends exactly DEPTH bytes
      for (int i = 0; i < DEPTH; i++) wr(i, 8'(i * 17 + 3));
      for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(i * 17 + 3));
      msg_len = 5'(DEPTH + 1);
      base    = n_tx;
      dbase   = n_done;
      pulse_start();
      wait_done(dbase + 1, 400);
      check("clamp_tx_count", n_tx - base, DEPTH);
      check("clamp_queue_empty", exp_q.size(), 0);

      // ACK timeout: UART ignores the strobe, byte is resent
      tick();
      check("retry_err_clear", int'(retry_err), 0);
      msg_len  = 5'd1;
      uart_ack = 1'b0;
      repeat (4) exp_q.push_back(8'h03);
      base  = n_tx;
      dbase = n_done;
      pulse_start();
      wait_tx(base + 3, 100);
      tick();
      uart_ack = 1'b1;
      check("retry_spacing_1", tx_cycs[base + 1] - tx_cycs[base], ACKTO + 1);
      check("retry_spacing_2", tx_cycs[base + 2] - tx_cycs[base + 1], ACKTO + 1);
      check("retry_err_set", int'(retry_err), 1);
      wait_done(dbase + 1, 100);
      check("retry_tx_count", n_tx - base, 4);
      tick();
      check("retry_err_sticky", int'(retry_err), 1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
